// File: rtl/dot_scan.sv
// dot_scan: row-multiplexed scan driver for the 16x8 dot-matrix LED panel.
// A shadow buffer holds newly loaded frames until the row 7 -> row 0 wrap,
// so the panel never shows half of one frame and half of another. Every row
// slot starts with a short dark interval to suppress ghosting.
// Optional feature macro: DOT_CURSOR_BLINK_EN (blinking cursor overlay).
module dot_scan #(
  parameter int ROW_CYCLES   = 5000,
  parameter int BLANK_CYCLES = 50
`ifdef DOT_CURSOR_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] frame_in,
  input  logic         frame_load,
`ifdef DOT_CURSOR_BLINK_EN
  input  logic         cursor_en,
  input  logic [6:0]   cursor_idx,
`endif
  output logic         frame_pending,
  output logic         frame_done,
  output logic         frame_tick,
  output logic [2:0]   row_idx,
  output logic [7:0]   dotR,
  output logic [15:0]  dotC
);

  localparam int CNT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       row_nxt;
  logic [127:0]     active;
  logic [127:0]     shadow;
  logic [127:0]     active_nxt;
  logic [127:0]     shadow_nxt;
  logic             pending_nxt;
  logic             done_nxt;
  logic             slot_end;
  logic             boundary;
  logic             blank_nxt;
  logic [15:0]      row_data;

`ifdef DOT_CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_nxt;
  logic               phase;
  logic               phase_nxt;
`endif

  // Next scan position plus the load/commit handshake; commits only at the frame wrap
  always_comb begin
    slot_end    = (cnt == CNT_LAST);
    boundary    = slot_end && (row_idx == 3'd7);
    cnt_nxt     = slot_end ? '0 : cnt + 1'b1;
    row_nxt     = slot_end ? row_idx + 3'd1 : row_idx;
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = frame_pending;
    done_nxt    = 1'b0;
    if (boundary) begin
      if (frame_load) begin
        active_nxt  = frame_in;
        shadow_nxt  = frame_in;
        pending_nxt = 1'b0;
        done_nxt    = 1'b1;
      end else if (frame_pending) begin
        active_nxt  = shadow;
        pending_nxt = 1'b0;
        done_nxt    = 1'b1;
      end
    end else if (frame_load) begin
      shadow_nxt  = frame_in;
      pending_nxt = 1'b1;
    end
  end

`ifdef DOT_CURSOR_BLINK_EN
  // Blink phase flips once every BLINK_FRAMES frame wraps
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    if (boundary) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = '0;
        phase_nxt     = ~phase;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end
  end
`endif

  // Column data for the upcoming cycle, taken from the buffer as it will be after this edge
  always_comb begin
    blank_nxt = int'(cnt_nxt) < BLANK_CYCLES;
    row_data  = active_nxt[{row_nxt, 4'b0000} +: 16];
`ifdef DOT_CURSOR_BLINK_EN
    if (cursor_en && phase_nxt && (cursor_idx[6:4] == row_nxt)) begin
      row_data[cursor_idx[3:0]] = ~row_data[cursor_idx[3:0]];
    end
`endif
  end

  // State and registered panel outputs, all matching the scan position of the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      row_idx       <= 3'd0;
      active        <= '0;
      shadow        <= '0;
      frame_pending <= 1'b0;
      frame_done    <= 1'b0;
      frame_tick    <= 1'b0;
      dotR          <= 8'hFF;
      dotC          <= 16'h0000;
    end else begin
      cnt           <= cnt_nxt;
      row_idx       <= row_nxt;
      active        <= active_nxt;
      shadow        <= shadow_nxt;
      frame_pending <= pending_nxt;
      frame_done    <= done_nxt;
      frame_tick    <= boundary;
      dotR          <= blank_nxt ? 8'hFF : ~(8'h80 >> row_nxt);
      dotC          <= blank_nxt ? 16'h0000 : row_data;
    end
  end

`ifdef DOT_CURSOR_BLINK_EN
  // Blink bookkeeping registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dot_scan.sv
// tb_dot_scan: self-checking bench for dot_scan with ROW_CYCLES=8, BLANK_CYCLES=2.
// Cycle n is the n-th clock period after reset release; the scan position and
// frame contents are predicted from plain arithmetic on n plus a frame-level
// model of the load handshake.
module tb_dot_scan;

  localparam int RC = 8;
  localparam int BC = 2;
  localparam int FP = 8 * RC;
  localparam int BF = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] frame_in = '0;
  logic         frame_load = 1'b0;
`ifdef DOT_CURSOR_BLINK_EN
  logic         cursor_en = 1'b0;
  logic [6:0]   cursor_idx = '0;
`endif
  logic         frame_pending;
  logic         frame_done;
  logic         frame_tick;
  logic [2:0]   row_idx;
  logic [7:0]   dotR;
  logic [15:0]  dotC;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [127:0] m_active;
  logic [127:0] m_shadow;
  logic         m_pending;
  logic         m_done;
  logic         m_tick;
  logic         m_cur_en;
  logic [6:0]   m_cur_idx;
  int           cyc;

  dot_scan #(
    .ROW_CYCLES(RC),
    .BLANK_CYCLES(BC)
`ifdef DOT_CURSOR_BLINK_EN
    ,
    .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_in(frame_in),
    .frame_load(frame_load),
`ifdef DOT_CURSOR_BLINK_EN
    .cursor_en(cursor_en),
    .cursor_idx(cursor_idx),
`endif
    .frame_pending(frame_pending),
    .frame_done(frame_done),
    .frame_tick(frame_tick),
    .row_idx(row_idx),
    .dotR(dotR),
    .dotC(dotC)
  );

  always #5 clock = ~clock;

  function automatic logic [29:0] observed();
    return {row_idx, dotR, dotC, frame_tick, frame_done, frame_pending};
  endfunction

  // Expected {row_idx, dotR, dotC, tick, done, pending} for the current cycle
  function automatic logic [29:0] expected();
    int slot;
    int row;
    int ci;
    logic [7:0]  r;
    logic [15:0] c;
    slot = cyc % RC;
    row  = (cyc / RC) % 8;
    r    = 8'hFF;
    c    = 16'h0000;
    if (slot >= BC) begin
      r[7 - row] = 1'b0;
      c = m_active[row * 16 +: 16];
      ci = int'(m_cur_idx);
      if (m_cur_en && (((cyc / FP) / BF) % 2 == 1) && (ci / 16 == row)) begin
        c[ci % 16] = ~c[ci % 16];
      end
    end
    return {3'(row), r, c, m_tick, m_done, m_pending};
  endfunction

  task automatic model_reset();
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
    m_done    = 1'b0;
    m_tick    = 1'b0;
    m_cur_en  = 1'b0;
    m_cur_idx = '0;
    cyc       = 0;
  endtask

  // Advance one clock; the model absorbs the inputs held across that edge
  task automatic step();
    @(posedge clock);
    m_tick = (cyc % FP == FP - 1);
    m_done = 1'b0;
    if (m_tick) begin
      if (frame_load) begin
        m_active  = frame_in;
        m_shadow  = frame_in;
        m_pending = 1'b0;
        m_done    = 1'b1;
      end else if (m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
        m_done    = 1'b1;
      end
    end else if (frame_load) begin
      m_shadow  = frame_in;
      m_pending = 1'b1;
    end
`ifdef DOT_CURSOR_BLINK_EN
    m_cur_en  = cursor_en;
    m_cur_idx = cursor_idx;
`endif
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    frame_load = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [7:0] plan_r [9];
    plan_r = '{8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF};
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (observed() !== {3'd0, 8'hFF, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %h expected %h", observed(), {3'd0, 8'hFF, 16'h0000, 3'b000});
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if ({row_idx, dotR, dotC} !== {3'(i / 8), plan_r[i], 16'h0000}) begin
        n_fail++;
        $display("[TB] FAIL first_slots cycle %0d: got %h expected %h", i, {row_idx, dotR, dotC}, {3'(i / 8), plan_r[i], 16'h0000});
      end
      step();
    end
  endtask

  task automatic test_load_commit();
    logic [127:0] f;
    f = '0;
    f[15:0]    = 16'hA5A5;
    f[127:112] = 16'h8001;
    apply_reset();
    frame_in = f;
    while (cyc < 2 * FP) begin
      frame_load = (cyc == 10);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL load_commit cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      if (cyc == 66 || cyc == 122) begin
        n_checks++;
        if ({dotR, dotC} !== ((cyc == 66) ? {8'h7F, 16'hA5A5} : {8'hFE, 16'h8001})) begin
          n_fail++;
          $display("[TB] FAIL load_commit_rows cycle %0d: got %h", cyc, {dotR, dotC});
        end
      end
      step();
    end
    frame_load = 1'b0;
  endtask

  task automatic test_latest_wins();
    int dones;
    dones = 0;
    apply_reset();
    while (cyc < 2 * FP) begin
      frame_load = (cyc == 5) || (cyc == 20);
      frame_in   = (cyc < 20) ? 128'h1111 : 128'h2222;
      if (frame_done === 1'b1) dones++;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL latest_wins cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      if (cyc == 66) begin
        n_checks++;
        if (dotC !== 16'h2222) begin
          n_fail++;
          $display("[TB] FAIL latest_wins_row0: got %h expected 2222", dotC);
        end
      end
      step();
    end
    frame_load = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("[TB] FAIL latest_wins_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_boundary_bypass();
    apply_reset();
    frame_in = 128'h00FF;
    while (cyc < 2 * FP) begin
      frame_load = (cyc == FP - 1);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL bypass cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      if (cyc == FP) begin
        n_checks++;
        if ({frame_tick, frame_done, frame_pending} !== 3'b110) begin
          n_fail++;
          $display("[TB] FAIL bypass_flags: got %b expected 110", {frame_tick, frame_done, frame_pending});
        end
      end
      step();
    end
    frame_load = 1'b0;
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    while (cyc < FP + 30) begin
      frame_load = (cyc == 10) || (cyc == FP + 20);
      frame_in   = (cyc < FP) ? {8{16'h3C3C}} : {8{16'hFFFF}};
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL midframe_pre cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      step();
    end
    frame_load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (observed() !== {3'd0, 8'hFF, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("[TB] FAIL midframe_async_reset: got %h expected %h", observed(), {3'd0, 8'hFF, 16'h0000, 3'b000});
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    while (cyc < 2 * FP + 8) begin
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL midframe_post cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      step();
    end
  endtask

  task automatic test_random();
    apply_reset();
    while (cyc < 6 * FP) begin
      frame_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      frame_load = (cyc % FP == FP - 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      step();
    end
    frame_load = 1'b0;
  endtask

`ifdef DOT_CURSOR_BLINK_EN
  task automatic test_cursor_blink();
    frame_in   = '0;
    cursor_en  = 1'b1;
    cursor_idx = 7'd17;
    apply_reset();
    while (cyc < 8 * FP) begin
      if (cyc == 6 * FP) cursor_en = 1'b0;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("[TB] FAIL cursor cycle %0d: got %h expected %h", cyc, observed(), expected());
      end
      if (cyc == 2 * FP + 10 || cyc == FP + 10 || cyc == 4 * FP + 10) begin
        n_checks++;
        if (dotC !== ((cyc == 2 * FP + 10) ? 16'h0002 : 16'h0000)) begin
          n_fail++;
          $display("[TB] FAIL cursor_row1 cycle %0d: got %h", cyc, dotC);
        end
      end
      step();
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_load_commit();
    test_latest_wins();
    test_boundary_bypass();
    test_reset_midframe();
    test_random();
`ifdef DOT_CURSOR_BLINK_EN
    test_cursor_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
